// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU-side signal bundle of the UART receive front end.
// Carries the serial line, the FIFO read port and the status/interrupt flags.
// Optional feature macro: UART_RX_PARITY_EN adds the parity_err flag.
interface uart_rx_fifo_if #(
    parameter int FIFO_AW = 2
);
    logic             rx_in;      // serial line, idle high, asynchronous
    logic             rd_en;      // pop strobe
    logic             err_clr;    // clears the sticky error flags
    logic [7:0]       rd_data;    // FIFO head, 8'h00 when empty
    logic             rx_valid;   // FIFO not empty
    logic [FIFO_AW:0] rx_count;   // entries held
    logic             frame_err;  // sticky: stop bit sampled low
    logic             overrun;    // sticky: byte dropped on full FIFO
`ifdef UART_RX_PARITY_EN
    logic             parity_err; // sticky: even-parity mismatch
`endif
    logic             int_req;    // level interrupt to the CPU

`ifdef UART_RX_PARITY_EN
    modport master (
        output rx_in, rd_en, err_clr,
        input  rd_data, rx_valid, rx_count, frame_err, overrun, parity_err, int_req
    );
    modport slave (
        input  rx_in, rd_en, err_clr,
        output rd_data, rx_valid, rx_count, frame_err, overrun, parity_err, int_req
    );
`else
    modport master (
        output rx_in, rd_en, err_clr,
        input  rd_data, rx_valid, rx_count, frame_err, overrun, int_req
    );
    modport slave (
        input  rx_in, rd_en, err_clr,
        output rd_data, rx_valid, rx_count, frame_err, overrun, int_req
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling 8N1 UART receiver feeding a small show-ahead FIFO.
// The line is double-flopped, frames are sampled mid-bit, LSB first, and good
// bytes are pushed one clock after the stop-bit sample. int_req drives CPU int0.
// Optional feature macro: UART_RX_PARITY_EN inserts an even-parity bit check.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // The IDLE detection cycle is the first cycle of the half bit, so START
    // needs two fewer counts to land the start-bit sample mid-bit.
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0]   FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH     = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic               rx_meta_q, rx_s_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               push_q, push_d;
    logic               frame_set;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_set;
    logic               parity_err_q;
`endif

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               frame_err_q, overrun_q;
    logic               pop, full, do_push, overrun_set;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver FSM state, counters and the registered push strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic: mid-bit sampling of start, data, parity and stop bits.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;  // high at mid-bit is a glitch
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d      = '0;
                    par_bad_d  = rx_s_q ^ (^shift_q);  // even parity: bit must equal XOR of data
                    parity_set = par_bad_d;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                        push_d = !par_bad_q;
`else
                        push_d = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_IDLE;  // a held break must not start a new frame
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO control: a pop on the push cycle frees the slot, so a full FIFO still accepts.
    assign pop         = bus.rd_en && (count_q != '0);
    assign full        = (count_q == DEPTH);
    assign do_push     = push_q && (!full || pop);
    assign overrun_set = push_q && full && !pop;

    // FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (!do_push && pop) count_d = count_q - 1'b1;
    end

    // FIFO pointers, count and sticky error flags; a set wins over err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_set   | (frame_err_q & ~bus.err_clr);
            overrun_q   <= overrun_set | (overrun_q & ~bus.err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_set | (parity_err_q & ~bus.err_clr);
`endif
        end
    end

    // FIFO storage; the byte is taken from the shift register one clock after the stop sample.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count_q gates every read, so stale contents are never visible.
        if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.rd_data   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.rx_valid  = (count_q != '0);
    assign bus.rx_count  = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
    assign bus.int_req    = (count_q != '0) | frame_err_q | overrun_q | parity_err_q;
`else
    assign bus.int_req    = (count_q != '0) | frame_err_q | overrun_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for uart_rx_fifo.
// Frames are driven serially; a queue-based model predicts FIFO contents and flags.
// Honours UART_RX_PARITY_EN when defined for both DUT and bench.
module tb_uart_rx_fifo;
    localparam int C  = 4;
    localparam int D  = 4;
    localparam int AW = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int PARW  = 1;
`else
    localparam int NBITS = 10;
    localparam int PARW  = 0;
`endif
    // Edges from start-bit fall to rx_valid=1, straight from the latency rule.
    localparam int LATENCY = 2 + C / 2 + 9 * C + 1 + PARW * C;

    logic clk;
    logic rst;

    uart_rx_fifo_if #(.FIFO_AW(AW)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D),
        .FIFO_AW     (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned model_q[$];
    bit m_frame, m_over, m_par;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic byte unsigned model_head();
        return (model_q.size() != 0) ? model_q[0] : 8'h00;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".count"},     32'(bus.rx_count),  32'(model_q.size()));
        check({tag, ".valid"},     32'(bus.rx_valid),  32'(model_q.size() != 0));
        check({tag, ".rd_data"},   32'(bus.rd_data),   32'(model_head()));
        check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_frame));
        check({tag, ".overrun"},   32'(bus.overrun),   32'(m_over));
`ifdef UART_RX_PARITY_EN
        check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(m_par));
`endif
        check({tag, ".int_req"}, 32'(bus.int_req),
              32'((model_q.size() != 0) || m_frame || m_over || m_par));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame, then hold_low bit times of low line, then 2 idle bit times.
    // With pop_on_push, rd_en is high exactly on the push edge.
    task automatic send_frame(input string tag, input byte unsigned data, input bit stop_ok,
                              input bit par_ok, input bit pop_on_push, input int hold_low,
                              output int valid_edge);
        logic [10:0] fr;
        int total;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1 + i] = data[i];
        if (PARW != 0) fr[9] = (^data) ^ ~par_ok;
        fr[NBITS - 1] = stop_ok;
        total = NBITS * C + hold_low * C + 2 * C;
        valid_edge = -1;
        for (int e = 1; e <= total; e++) begin
            if (e <= NBITS * C)                     bus.rx_in = fr[(e - 1) / C];
            else if (e <= NBITS * C + hold_low * C) bus.rx_in = 1'b0;
            else                                    bus.rx_in = 1'b1;
            if (pop_on_push && e == LATENCY) begin
                check({tag, ".pop_head"}, 32'(bus.rd_data), 32'(model_head()));
                bus.rd_en = 1'b1;
                if (model_q.size() != 0) void'(model_q.pop_front());
            end else begin
                bus.rd_en = 1'b0;
            end
            tick();
            if (valid_edge < 0 && bus.rx_valid) valid_edge = e;
            if (hold_low > 0 && e == NBITS * C + hold_low * C)
                check({tag, ".hold_count"}, 32'(bus.rx_count), 32'(model_q.size()));
        end
        bus.rd_en = 1'b0;
        if (!stop_ok) m_frame = 1'b1;
        if (PARW != 0 && !par_ok) m_par = 1'b1;
        if (stop_ok && (par_ok || PARW == 0)) begin
            if (model_q.size() < D) model_q.push_back(data);
            else                    m_over = 1'b1;
        end
    endtask

    task automatic read_one(input string tag);
        check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(model_head()));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        check({tag, ".count"}, 32'(bus.rx_count), 32'(model_q.size()));
    endtask

    task automatic clear_errors();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        m_frame = 1'b0;
        m_over  = 1'b0;
        m_par   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vedge;
        byte unsigned seq[5];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5};

        rst         = 1'b0;
        bus.rx_in   = 1'b1;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        m_frame = 1'b0;
        m_over  = 1'b0;
        m_par   = 1'b0;
        repeat (3) tick();
        check_status("reset");
        rst = 1'b1;
        repeat (2) tick();

        // Single byte: latency, show-ahead data, then drain.
        send_frame("b55", 8'h55, 1'b1, 1'b1, 1'b0, 0, vedge);
        check("b55.latency", 32'(vedge), 32'(LATENCY));
        check_status("b55");
        read_one("b55.rd");
        check_status("b55.empty");

        // Fill past full without reads: overrun, contents preserved.
        foreach (seq[i]) send_frame("fill", seq[i], 1'b1, 1'b1, 1'b0, 0, vedge);
        check_status("ovr");
        for (int i = 0; i < D; i++) read_one("ovr.rd");
        read_one("ovr.rd_empty");
        clear_errors();
        check_status("ovr.clr");

        // Full FIFO with a pop on the push edge: no overrun.
        foreach (seq[i]) send_frame("popush", seq[i], 1'b1, 1'b1, i == 4, 0, vedge);
        check_status("popush");
        for (int i = 0; i < D; i++) read_one("popush.rd");

        // Short low glitch on the line.
        bus.rx_in = 1'b0;
        repeat (C / 2 - 1) tick();
        bus.rx_in = 1'b1;
        repeat (2 * C) tick();
        check_status("glitch");

        // Framing error followed by a long break, then a good byte.
        send_frame("brk", 8'h3C, 1'b0, 1'b1, 1'b0, 20, vedge);
        check_status("brk");
        send_frame("b7e", 8'h7E, 1'b1, 1'b1, 1'b0, 0, vedge);
        check_status("b7e");
        read_one("b7e.rd");
        clear_errors();
        check_status("b7e.clr");

        // Randomized traffic against the queue model.
        for (int n = 0; n < 24; n++) begin
            byte unsigned d;
            bit s_ok, p_ok, pp;
            bit was_empty;
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
            p_ok = (PARW == 0) || ($urandom_range(0, 5) != 0);
            pp   = (model_q.size() == D) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
            was_empty = (model_q.size() == 0);
            send_frame("rnd", d, s_ok, p_ok, pp, 0, vedge);
            if (was_empty && model_q.size() != 0) check("rnd.latency", 32'(vedge), 32'(LATENCY));
            check_status("rnd");
            repeat ($urandom_range(0, 2)) read_one("rnd.rd");
            if ($urandom_range(0, 5) == 0) begin
                clear_errors();
                check_status("rnd.clr");
            end
        end

        // Reset in the middle of a frame, then a fresh byte.
        send_frame("pre", 8'h11, 1'b1, 1'b1, 1'b0, 0, vedge);
        bus.rx_in = 1'b0;
        repeat (C) tick();
        bus.rx_in = 1'b1;
        repeat (3 * C) tick();
        #3 rst = 1'b0;
        #1;
        model_q.delete();
        m_frame = 1'b0;
        m_over  = 1'b0;
        m_par   = 1'b0;
        check_status("midrst");
        tick();
        rst = 1'b1;
        repeat (2) tick();
        check_status("postrst");
        send_frame("b81", 8'h81, 1'b1, 1'b1, 1'b0, 0, vedge);
        check("b81.latency", 32'(vedge), 32'(LATENCY));
        check_status("b81");
        read_one("b81.rd");
`ifdef UART_RX_PARITY_EN
        send_frame("par", 8'h81, 1'b1, 1'b0, 1'b0, 0, vedge);
        check_status("par");
        clear_errors();
        check_status("par.clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
